order_manager: RTL

ORDER_MANAGER -- requirements
Module: order_manager

---
 rtl/trading_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/order_manager.sv | 135 +++++++++++++
 3 files changed

// File: rtl/trading_pkg.sv
// trading_pkg: shared strategy codes, reject codes and order-manager FSM states
package trading_pkg;

    localparam logic [7:0] SIG_ARB  = 8'h01;
    localparam logic [7:0] SIG_MM   = 8'h02;
    localparam logic [7:0] SIG_MOM  = 8'h03;
    localparam logic [7:0] SIG_MR   = 8'h04;

    localparam logic [2:0] REJ_NONE = 3'd0;
    localparam logic [2:0] REJ_HALT = 3'd1;
    localparam logic [2:0] REJ_TYPE = 3'd2;
    localparam logic [2:0] REJ_ZERO = 3'd3;
    localparam logic [2:0] REJ_QTY  = 3'd4;
    localparam logic [2:0] REJ_CONF = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_DRAIN,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock queue with simultaneous push/pop and a keep-head flush
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;
    logic             keep;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~flush & (~full | do_pop);
    assign keep    = ~empty & ~do_pop;
    assign rdata   = mem[rd_ptr];

    // storage write, no reset needed since reads are gated by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers; flush keeps only the head entry unless it leaves this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= rd_ptr + AW'(do_pop) + AW'(keep);
            count  <= CW'(keep);
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/order_manager.sv
// order_manager: validates strategy signals, queues orders and hands them to the gateway
module order_manager
    import trading_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    FIFO_DEPTH     = 8,
    parameter logic [DATA_WIDTH-1:0] MAX_ORDER_QTY  = DATA_WIDTH'(32'h0001_0000),
    parameter logic [DATA_WIDTH-1:0] MIN_CONFIDENCE = DATA_WIDTH'(32'h0000_0040)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_valid,
    input  logic [DATA_WIDTH-1:0] signal_symbol,
    input  logic [DATA_WIDTH-1:0] signal_price,
    input  logic [DATA_WIDTH-1:0] signal_volume,
    input  logic [DATA_WIDTH-1:0] signal_confidence,
    input  logic [7:0]            signal_type,
    input  logic                  kill_switch,
    output logic                  order_valid,
    input  logic                  order_ready,
    output logic [15:0]           order_id,
    output logic [DATA_WIDTH-1:0] order_symbol,
    output logic [DATA_WIDTH-1:0] order_price,
    output logic [DATA_WIDTH-1:0] order_volume,
    output logic [7:0]            order_type,
    output logic                  reject_valid,
    output logic [2:0]            reject_code,
    output logic                  overflow,
    output logic [31:0]           orders_sent
);

    localparam int FW = 3 * DATA_WIDTH + 8;

    state_t                state;
    state_t                state_nx;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_symbol;
    logic [DATA_WIDTH-1:0] s_price;
    logic [DATA_WIDTH-1:0] s_volume;
    logic [DATA_WIDTH-1:0] s_conf;
    logic [7:0]            s_type;
    logic [2:0]            code;
    logic                  pass;
    logic                  xfer;
    logic                  full;
    logic                  empty;
    logic [FW-1:0]         head;
    logic [15:0]           id_q;

    // check stage: hold each incoming beat for one cycle of evaluation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid  <= 1'b0;
            s_symbol <= '0;
            s_price  <= '0;
            s_volume <= '0;
            s_conf   <= '0;
            s_type   <= '0;
        end else begin
            s_valid <= signal_valid;
            if (signal_valid) begin
                s_symbol <= signal_symbol;
                s_price  <= signal_price;
                s_volume <= signal_volume;
                s_conf   <= signal_confidence;
                s_type   <= signal_type;
            end
        end
    end

    // reject priority: halted, bad type, zero volume, oversize, low confidence
    always_comb begin
        code = (state != ST_RUN)                                     ? REJ_HALT :
               !(s_type inside {SIG_ARB, SIG_MM, SIG_MOM, SIG_MR})   ? REJ_TYPE :
               (s_volume == '0)                                      ? REJ_ZERO :
               (s_volume > MAX_ORDER_QTY)                            ? REJ_QTY  :
               (s_conf < MIN_CONFIDENCE)                             ? REJ_CONF : REJ_NONE;
    end

    assign pass         = s_valid & (code == REJ_NONE);
    assign reject_valid = s_valid & (code != REJ_NONE);
    assign reject_code  = reject_valid ? code : REJ_NONE;
    assign order_valid  = ~empty;
    assign xfer         = order_valid & order_ready;
    assign {order_symbol, order_price, order_volume, order_type} = order_valid ? head : '0;
    assign order_id     = order_valid ? id_q : 16'd0;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pass),
        .pop   (xfer),
        .flush (state == ST_HALT_DRAIN),
        .wdata ({s_symbol, s_price, s_volume, s_type}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // halt FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nx;
    end

    // halt FSM: drain leaves once the presented order has gone
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:        state_nx = kill_switch ? ST_HALT_DRAIN : ST_RUN;
            ST_HALT_DRAIN: state_nx = empty ? ST_HALTED : ST_HALT_DRAIN;
            ST_HALTED:     state_nx = kill_switch ? ST_HALTED : ST_RUN;
            default:       state_nx = ST_RUN;
        endcase
    end

    // sequence id, handshake count and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q        <= 16'd1;
            orders_sent <= 32'd0;
            overflow    <= 1'b0;
        end else begin
            if (xfer) begin
                id_q        <= (id_q == 16'hFFFF) ? 16'd1 : id_q + 16'd1;
                orders_sent <= orders_sent + 32'd1;
            end
            if (pass & full & ~xfer) overflow <= 1'b1;
        end
    end

endmodule
